// File: rtl/cam_cfg_sequencer.sv
// Walks the shared OV7670 config ROM once per camera request, issuing SCCB writes
// with NACK/timeout retry, millisecond delay entries and round-robin camera arbitration.
module cam_cfg_sequencer #(
  parameter int ROM_AW       = 8,
  parameter int CLK_HZ       = 100_000_000,
  parameter int MAX_RETRY    = 3,
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_req,
  output logic              cfg_busy,
  output logic [1:0]        cfg_done,
  output logic [1:0]        cfg_err,
  output logic              cam_sel,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic [2:0]        dbg_state
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int DLY_W  = $clog2(255 * MS_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic              rr_last_q, rr_last_d;
  logic              cam_sel_q, cam_sel_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        cfg_done_q, cfg_done_d;
  logic [1:0]        cfg_err_q, cfg_err_d;
  logic              sccb_start_q, sccb_start_d;
  logic [7:0]        sccb_reg_q, sccb_reg_d;
  logic [7:0]        sccb_val_q, sccb_val_d;
  logic [7:0]        retry_q, retry_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;

  logic       pick;
  logic [1:0] pend_clr;
  logic [1:0] cam_mask;
  logic       adv;
  logic       fail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 2'b11;
      rr_last_q    <= 1'b1;
      cam_sel_q    <= 1'b0;
      rom_addr_q   <= '0;
      cfg_done_q   <= 2'b00;
      cfg_err_q    <= 2'b00;
      sccb_start_q <= 1'b0;
      sccb_reg_q   <= 8'h00;
      sccb_val_q   <= 8'h00;
      retry_q      <= 8'h00;
      dly_q        <= '0;
      wait_cnt_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_last_q    <= rr_last_d;
      cam_sel_q    <= cam_sel_d;
      rom_addr_q   <= rom_addr_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      sccb_start_q <= sccb_start_d;
      sccb_reg_q   <= sccb_reg_d;
      sccb_val_q   <= sccb_val_d;
      retry_q      <= retry_d;
      dly_q        <= dly_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    cam_sel_d    = cam_sel_q;
    rom_addr_d   = rom_addr_q;
    cfg_done_d   = cfg_done_q;
    cfg_err_d    = cfg_err_q;
    sccb_start_d = 1'b0;
    sccb_reg_d   = sccb_reg_q;
    sccb_val_d   = sccb_val_q;
    retry_d      = retry_q;
    dly_d        = dly_q;
    wait_cnt_d   = wait_cnt_q;
    pend_clr     = 2'b00;
    adv          = 1'b0;
    fail         = 1'b0;
    // With both cameras pending, the one not served last wins.
    pick     = (pending_q == 2'b11) ? ~rr_last_q : pending_q[1];
    cam_mask = cam_sel_q ? 2'b10 : 2'b01;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          pend_clr   = pick ? 2'b10 : 2'b01;
          cam_sel_d  = pick;
          rr_last_d  = pick;
          cfg_done_d = cfg_done_q & ~pend_clr;
          cfg_err_d  = cfg_err_q & ~pend_clr;
          rom_addr_d = '0;
          retry_d    = 8'h00;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_d = S_FINISH;
        end else if (rom_data[15:8] == 8'hF0) begin
          dly_d = DLY_W'(rom_data[7:0]) * DLY_W'(MS_CYC);
          if (rom_data[7:0] == 8'h00) adv = 1'b1;
          else state_d = S_DELAY;
        end else begin
          sccb_reg_d = rom_data[15:8];
          sccb_val_d = rom_data[7:0];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!sccb_busy) begin
          sccb_start_d = 1'b1;
          wait_cnt_d   = 16'h0000;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sccb_done) begin
          if (!sccb_nack) begin
            retry_d = 8'h00;
            adv     = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (wait_cnt_q == 16'(WAIT_TIMEOUT)) begin
          fail = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'h0001;
        end
        // A failed write is re-issued unchanged until the retry budget is spent.
        if (fail) begin
          if (retry_q >= 8'(MAX_RETRY)) begin
            cfg_err_d = cfg_err_q | cam_mask;
            retry_d   = 8'h00;
            state_d   = S_IDLE;
          end else begin
            retry_d = retry_q + 8'h01;
            state_d = S_ISSUE;
          end
        end
      end
      S_DELAY: begin
        if (dly_q <= DLY_W'(1)) adv = 1'b1;
        else dly_d = dly_q - DLY_W'(1);
      end
      S_FINISH: begin
        cfg_done_d = cfg_done_q | cam_mask;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The last ROM slot ends the pass so the address never wraps.
    if (adv) begin
      if (rom_addr_q == '1) begin
        state_d = S_FINISH;
      end else begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
        state_d    = S_FETCH;
      end
    end

    pending_d = (pending_q & ~pend_clr) | cfg_req;
  end

  assign cfg_busy   = (state_q != S_IDLE);
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign cam_sel    = cam_sel_q;
  assign rom_addr   = rom_addr_q;
  assign sccb_start = sccb_start_q;
  assign sccb_reg   = sccb_reg_q;
  assign sccb_val   = sccb_val_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
- Sequences OV7670 register configuration for both cameras (CAM1 dice, CAM2 face) through one shared SCCB write master and one shared config ROM.
- Arbitrates per-camera (re)configuration requests round-robin and drives the SCCB bus mux select (cam_sel).
- Auto-configures both cameras after reset, then services runtime requests, e.g. a mode change from the top level.

Parameters:
- ROM_AW, 8, config ROM address width. The table holds up to 2^ROM_AW entries.
- CLK_HZ, 100_000_000, clk frequency. One ms equals MS_CYC = CLK_HZ/1000 cycles.
- MAX_RETRY, 3, maximum re-issues of a NACKed write before the camera is marked failed.
- WAIT_TIMEOUT, 65535, cycles allowed in WAIT without sccb_done. On expiry, the write is treated as a NACK.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_req  in  2  per-camera configuration request pulse. bit0 = CAM1, bit1 = CAM2.
- cfg_busy  out  1  high in any state other than IDLE.
- cfg_done  out  2  sticky, per camera: last configuration completed OK.
- cfg_err  out  2  sticky, per camera: last configuration aborted.
- cam_sel  out  1  SCCB mux select. 0 = CAM1, 1 = CAM2. Held constant while cfg_busy.
- rom_addr  out  ROM_AW  config ROM address.
- rom_data  in  16  {reg, val}. Synchronous ROM: valid 1 cycle after rom_addr.
- sccb_start  out  1  one-cycle write strobe to the SCCB master.
- sccb_reg  out  8  register address for the write. Stable from sccb_start until sccb_done.
- sccb_val  out  8  write data. Stable from sccb_start until sccb_done.
- sccb_busy  in  1  SCCB master is busy.
- sccb_done  in  1  one-cycle pulse: write finished.
- sccb_nack  in  1  NACK status. Sampled only with sccb_done.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - All outputs = 0.
  - pending = 2'b11, rr_last = 1, so CAM1 is served first.
  - retry = 0, delay counter = 0.
  - sccb_start drops immediately. An in-flight write is abandoned.
- Request capture:
  - Every cycle, pending |= cfg_req.
  - The same-cycle clear of the selected bit in IDLE loses to a new request for that same bit, so a simultaneous request is kept.
- IDLE:
  - If pending != 0, pick a camera round-robin: the other camera is preferred over rr_last if both are pending.
  - Set cam_sel = pick, rr_last = pick, clear pending[pick], clear cfg_done[pick] and cfg_err[pick], set rom_addr = 0.
  - Go to FETCH. cfg_busy rises on the next cycle.
- FETCH: wait one cycle for ROM latency, then go to DECODE.
- DECODE, based on rom_data:
  - 16'hFFFF (end marker): go to FINISH.
  - Upper byte 8'hF0 (delay entry): load delay = val ms.
    - val = 0: advance directly.
    - Otherwise go to DELAY.
  - Any other value: latch sccb_reg/sccb_val and go to ISSUE.
- ISSUE: wait while sccb_busy. When sccb_busy = 0, pulse sccb_start for exactly 1 cycle and go to WAIT.
- WAIT, on sccb_done:
  - ACK: retry = 0, advance.
  - NACK with retry < MAX_RETRY: retry++, go to ISSUE with the same reg/val.
  - NACK with retry == MAX_RETRY: cfg_err[cam] = 1, retry = 0, go to IDLE. The remaining table is skipped.
  - Timeout: a 16-bit counter reaching WAIT_TIMEOUT is handled exactly as a NACK.
- DELAY: count val × MS_CYC cycles, then advance.
- Advance:
  - If rom_addr == 2^ROM_AW−1, go to FINISH. This covers a missing end marker and the address never wraps.
  - Otherwise rom_addr++ and go to FETCH.
- FINISH: cfg_done[cam] = 1, go to IDLE. cfg_busy falls on the next cycle.
- Throughput: each plain write costs FETCH + DECODE + ISSUE (≥1) + WAIT cycles.
- cfg_req for the camera currently being configured sets pending. That camera is re-run after the current pass, behind the other camera if the other is also pending.
- sccb_done outside WAIT is ignored.

Test Plan:
- Power-up with ROM {0x1280, 0x1114, F000, FFFF} and an ACKing SCCB model.
  - CAM1 gets writes (12,80) then (11,14); CAM2 then gets the same two writes.
  - cfg_done = 2'b11, cfg_err = 0, exactly 4 sccb_start pulses, cam_sel 0→1.
- Delay entry F002 with CLK_HZ = 10_000.
  - Exactly 20 cycles in DELAY between the surrounding writes.
- NACK the 1st write three times, then ACK.
  - 4 starts with the same reg/val, cfg_err = 0, done set.
  - NACK four times: cfg_err[cam] = 1 after the 4th start, later entries not issued, the other camera is still configured.
- After power-up, pulse cfg_req = 2'b11 in the same cycle.
  - Order CAM1 then CAM2 (rr_last = 1 → CAM1 preferred).
  - A cfg_req[0] pulse while CAM1 is busy causes a second CAM1 pass.
- sccb_busy held high 50 cycles in ISSUE: sccb_start is withheld until it falls. sccb_done never arrives with WAIT_TIMEOUT = 100: treated as NACK, with retries.
- Assert reset in the middle of WAIT.
  - All outputs 0 asynchronously.
  - After release, reconfiguration restarts from rom_addr 0 for CAM1.
- ROM with no FFFF entry and ROM_AW = 3: 8 writes issued, then cfg_done set, rom_addr does not wrap.
